// File: rtl/avoid_sequencer.sv
// Collision-avoidance motion sequencer: DRIVE until the collision flag drops, then
// brake, reverse, pivot (alternating side) and resume; latches FAULT after too many retries.
module avoid_sequencer #(
  parameter int BRAKE_CYC   = 50_000,
  parameter int REVERSE_CYC = 25_000_000,
  parameter int TURN_CYC    = 12_500_000,
  parameter int CLEAR_CYC   = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       col_detect,
  output logic [1:0] mot_l,
  output logic [1:0] mot_r,
  output logic [2:0] state_o,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_BRAKE   = 3'd2,
    S_REVERSE = 3'd3,
    S_TURN    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [25:0] BRAKE_LAST = 26'(BRAKE_CYC - 1);
  localparam logic [25:0] REV_LAST   = 26'(REVERSE_CYC - 1);
  localparam logic [25:0] TURN_LAST  = 26'(TURN_CYC - 1);
  localparam logic [25:0] CLEAR_LAST = 26'(CLEAR_CYC - 1);
  localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRY);

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b10;
  localparam logic [1:0] M_REV  = 2'b01;

  state_t      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [25:0] clear_q, clear_d;
  logic [2:0]  retry_q, retry_d;
  logic        dir_q, dir_d;
  logic [1:0]  mot_l_q, mot_l_d, mot_r_q, mot_r_d;
  logic        fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    clear_d = clear_q;
    retry_d = retry_q;
    dir_d   = dir_q;
    if (!enable) begin
      state_d = S_IDLE;
      clear_d = '0;
      retry_d = '0;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_DRIVE;
        S_DRIVE: begin
          // a collision on the clear-expiry cycle wins: retry count is kept
          if (!col_detect) begin
            clear_d = '0;
            if (retry_q == RETRY_MAX) state_d = S_FAULT;
            else begin
              retry_d = retry_q + 3'd1;
              state_d = S_BRAKE;
            end
          end else if (clear_q == CLEAR_LAST) begin
            retry_d = '0;
          end else begin
            clear_d = clear_q + 26'd1;
          end
        end
        S_BRAKE:   if (timer_q == BRAKE_LAST) state_d = S_REVERSE;
        S_REVERSE: if (timer_q == REV_LAST)   state_d = S_TURN;
        S_TURN: begin
          if (timer_q == TURN_LAST) begin
            state_d = S_DRIVE;
            dir_d   = ~dir_q;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
    timer_d = (!enable || state_d != state_q) ? '0 : timer_q + 26'd1;

    // outputs are decoded from the next state so they flip on the same edge
    mot_l_d = M_STOP;
    mot_r_d = M_STOP;
    case (state_d)
      S_DRIVE:   begin mot_l_d = M_FWD; mot_r_d = M_FWD; end
      S_REVERSE: begin mot_l_d = M_REV; mot_r_d = M_REV; end
      S_TURN: begin
        mot_l_d = dir_d ? M_FWD : M_REV;
        mot_r_d = dir_d ? M_REV : M_FWD;
      end
      default: ;
    endcase
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      clear_q <= '0;
      retry_q <= '0;
      dir_q   <= 1'b0;
      mot_l_q <= M_STOP;
      mot_r_q <= M_STOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      clear_q <= clear_d;
      retry_q <= retry_d;
      dir_q   <= dir_d;
      mot_l_q <= mot_l_d;
      mot_r_q <= mot_r_d;
      fault_q <= fault_d;
    end
  end

  assign mot_l   = mot_l_q;
  assign mot_r   = mot_r_q;
  assign state_o = state_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_avoid_sequencer.sv
// Cycle-accurate scoreboard bench for avoid_sequencer: expected {state,mot_l,mot_r,fault}
// is queued per stimulus cycle and compared one clock later.
module tb_avoid_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, enable, col_detect;
  logic [1:0] mot_l, mot_r;
  logic [2:0] state_o;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  localparam logic [7:0] E_IDLE  = 8'b000_00_00_0;
  localparam logic [7:0] E_DRIVE = 8'b001_10_10_0;
  localparam logic [7:0] E_BRAKE = 8'b010_00_00_0;
  localparam logic [7:0] E_REV   = 8'b011_01_01_0;
  localparam logic [7:0] E_TL    = 8'b100_01_10_0;
  localparam logic [7:0] E_TR    = 8'b100_10_01_0;
  localparam logic [7:0] E_FAULT = 8'b101_00_00_1;

  avoid_sequencer #(
    .BRAKE_CYC(4), .REVERSE_CYC(8), .TURN_CYC(6), .CLEAR_CYC(20), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col_detect(col_detect),
    .mot_l(mot_l), .mot_r(mot_r), .state_o(state_o), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic en, input logic col, input logic [7:0] e);
    enable     = en;
    col_detect = col;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, {state_o, mot_l, mot_r, fault}, sb.pop_front());
  endtask

  // one full manoeuvre starting from DRIVE; col drives the ignored cycles
  task automatic man(input string tag, input logic dir, input logic col);
    cyc({tag, "/brk0"}, 1'b1, 1'b0, E_BRAKE);
    repeat (3) cyc({tag, "/brk"}, 1'b1, col, E_BRAKE);
    repeat (8) cyc({tag, "/rev"}, 1'b1, col, E_REV);
    repeat (6) cyc({tag, "/turn"}, 1'b1, col, dir ? E_TR : E_TL);
    cyc({tag, "/resume"}, 1'b1, col, E_DRIVE);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; col_detect = 1'b1;
    #12;
    chk("reset", {state_o, mot_l, mot_r, fault}, E_IDLE);
    rst_n = 1'b1;

    cyc("idle_hold", 1'b0, 1'b1, E_IDLE);
    cyc("start", 1'b1, 1'b1, E_DRIVE);
    repeat (3) cyc("drive", 1'b1, 1'b1, E_DRIVE);

    // single pulses: left pivot first, then right
    man("pulse1", 1'b0, 1'b1);
    repeat (3) cyc("drive2", 1'b1, 1'b1, E_DRIVE);
    man("pulse2", 1'b1, 1'b1);
    cyc("off1", 1'b0, 1'b1, E_IDLE);

    // held collision: three manoeuvres then FAULT
    cyc("hold_start", 1'b1, 1'b1, E_DRIVE);
    man("hold1", 1'b0, 1'b0);
    man("hold2", 1'b1, 1'b0);
    man("hold3", 1'b0, 1'b0);
    cyc("hold_fault", 1'b1, 1'b0, E_FAULT);
    repeat (3) cyc("fault_stay", 1'b1, 1'b1, E_FAULT);
    cyc("fault_exit", 1'b0, 1'b1, E_IDLE);

    // 20 clear cycles between collisions reset the retry count
    cyc("clr_start", 1'b1, 1'b1, E_DRIVE);
    for (int i = 0; i < 5; i++) begin
      man("clr_man", (i % 2) == 1, 1'b1);
      repeat (20) cyc("clr_drive", 1'b1, 1'b1, E_DRIVE);
    end
    cyc("off2", 1'b0, 1'b1, E_IDLE);

    // collision on the clear-expiry cycle wins: retries still accumulate
    cyc("tie_start", 1'b1, 1'b1, E_DRIVE);
    man("tie1", 1'b0, 1'b1);
    repeat (19) cyc("tie_drive", 1'b1, 1'b1, E_DRIVE);
    man("tie2", 1'b1, 1'b1);
    repeat (19) cyc("tie_drive", 1'b1, 1'b1, E_DRIVE);
    man("tie3", 1'b0, 1'b1);
    repeat (19) cyc("tie_drive", 1'b1, 1'b1, E_DRIVE);
    cyc("tie_fault", 1'b1, 1'b0, E_FAULT);
    cyc("off3", 1'b0, 1'b1, E_IDLE);

    // enable dropped in the third REVERSE cycle
    cyc("abort_start", 1'b1, 1'b1, E_DRIVE);
    cyc("abort_brk0", 1'b1, 1'b0, E_BRAKE);
    repeat (3) cyc("abort_brk", 1'b1, 1'b1, E_BRAKE);
    repeat (3) cyc("abort_rev", 1'b1, 1'b1, E_REV);
    cyc("abort_idle", 1'b0, 1'b1, E_IDLE);
    cyc("abort_re", 1'b1, 1'b1, E_DRIVE);
    man("abort_after", 1'b0, 1'b1);
    cyc("off4", 1'b0, 1'b1, E_IDLE);

    // asynchronous reset in the middle of a right pivot
    cyc("rst_start", 1'b1, 1'b1, E_DRIVE);
    man("rst_m1", 1'b0, 1'b1);
    cyc("rst_brk0", 1'b1, 1'b0, E_BRAKE);
    repeat (3) cyc("rst_brk", 1'b1, 1'b1, E_BRAKE);
    repeat (8) cyc("rst_rev", 1'b1, 1'b1, E_REV);
    repeat (2) cyc("rst_turn", 1'b1, 1'b1, E_TR);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {state_o, mot_l, mot_r, fault}, E_IDLE);
    #1 rst_n = 1'b1;
    cyc("rst_re", 1'b1, 1'b1, E_DRIVE);
    man("rst_after", 1'b0, 1'b1);

    // random stimulus: forbidden motor code never appears
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 15) != 0);
      col_detect = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      chk("no_11", {7'd0, (mot_l == 2'b11) || (mot_r == 2'b11)}, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/avoid_sequencer.md
# avoid_sequencer

Motion sequencer that owns both drive motors and turns the debounced collision flag from the front-sensor collision detector into a fixed avoidance manoeuvre: brake, reverse, turn, resume. It sits between the collision detector and the H-bridge pins. Turn direction alternates on each manoeuvre. A retry counter latches a fault when the robot keeps colliding without a clear run.

## Interface
Parameters:
- `BRAKE_CYC`, 50_000: dwell cycles in BRAKE (1 ms at 50 MHz).
- `REVERSE_CYC`, 25_000_000: dwell cycles in REVERSE.
- `TURN_CYC`, 12_500_000: dwell cycles in TURN.
- `CLEAR_CYC`, 50_000_000: continuous clear-drive cycles needed to reset the retry count.
- `MAX_RETRY`, 3: manoeuvres allowed without a clear run before FAULT, range 1..7.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  run request from the top level; level-sensitive.
- `col_detect`  in  1  collision-detector output, already debounced; 1 = drive, 0 = stop/collision.
- `mot_l`  out  2  left motor, encoded {fwd,rev}: 10 forward, 01 reverse, 00 stop.
- `mot_r`  out  2  right motor, same encoding as `mot_l`.
- `state_o`  out  3  current state code, for the LEDs.
- `fault`  out  1  high while in FAULT.

## Operation
- States and codes: IDLE=0, DRIVE=1, BRAKE=2, REVERSE=3, TURN=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- Internal registers: `timer` (26 b, counts up from 0), `clear_cnt` (26 b), `retry_cnt` (3 b), `turn_dir` (1 b).
- `enable`=0 has the highest priority in every state. Next state is IDLE, and `timer`, `clear_cnt`, `retry_cnt` and `turn_dir` are all cleared.
- IDLE:
  - motors 00/00.
  - `enable`=1 moves to DRIVE.
- DRIVE:
  - motors 10/10.
  - `col_detect`=0 moves to BRAKE and clears `clear_cnt`.
  - Otherwise `clear_cnt` increments. When `clear_cnt`==CLEAR_CYC-1, `retry_cnt` is cleared and `clear_cnt` holds at that value.
- BRAKE entry, on the DRIVE→BRAKE edge:
  - If `retry_cnt`==MAX_RETRY, the next state is FAULT instead of BRAKE.
  - Otherwise `retry_cnt` increments and the next state is BRAKE.
- BRAKE:
  - motors 00/00.
  - When `timer`==BRAKE_CYC-1, move to REVERSE.
- REVERSE:
  - motors 01/01.
  - When `timer`==REVERSE_CYC-1, move to TURN.
- TURN:
  - `turn_dir`=0: `mot_l`=01, `mot_r`=10 (pivot left). `turn_dir`=1: the mirror image.
  - When `timer`==TURN_CYC-1, move to DRIVE and toggle `turn_dir`.
- `col_detect` is ignored in BRAKE, REVERSE and TURN. If it is still 0 on re-entering DRIVE, the next cycle starts a new manoeuvre and counts as a retry.
- FAULT:
  - motors 00/00, `fault`=1.
  - Exits only through `enable`=0, which goes to IDLE.
- `timer` clears on every state change and otherwise increments.
- Motor encoding 11 must never appear on either motor.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE, `state_o`=0;
  - `mot_l`=`mot_r`=00, `fault`=0;
  - all counters 0, `turn_dir`=0.
- The reset release edge takes effect synchronously; the first transition can happen on the first clock edge after release.
- All outputs are registered Moore outputs. They change on the same edge as the state register, so there is no combinational path from input to output.
- Dwell time in BRAKE, REVERSE and TURN is exactly the parameter value in cycles, counted from the entry edge to the exit edge.
- Latency:
  - `col_detect` falling while in DRIVE: motors read 00 after exactly 1 clock.
  - `enable` falling: motors read 00 after exactly 1 clock.
- Simultaneous events:
  - `enable`=0 together with a timer expiry: go to IDLE.
  - In DRIVE, `col_detect`=0 on the same cycle as `clear_cnt` expiry: the collision wins and `retry_cnt` is not cleared.
- Reset asserted mid-manoeuvre aborts it immediately. The next run starts in IDLE with `turn_dir`=0.

## Test plan
All scenarios use BRAKE_CYC=4, REVERSE_CYC=8, TURN_CYC=6, CLEAR_CYC=20, MAX_RETRY=3.
- Reset, then `enable`=1 with `col_detect`=1 → `state_o` 0 then 1; motors 10/10 one clock after `enable` is sampled; `fault`=0.
- Single 1-cycle `col_detect` low pulse in DRIVE → motors 00 for 4 cycles, 01/01 for 8, 01/10 for 6, then 10/10. A second pulse gives 10/01 in TURN.
- Hold `col_detect`=0 → three full manoeuvres run, then the fourth DRIVE→BRAKE edge goes to FAULT: `state_o`=5, `fault`=1, motors 00. Dropping `enable` → IDLE and `fault`=0 one clock later.
- Collision, then 20 clear DRIVE cycles, repeated 5 times → FAULT is never reached; `retry_cnt` stays ≤1.
- `enable` dropped in the 3rd REVERSE cycle → next clock IDLE, motors 00. Re-enable → DRIVE; the next TURN uses 01/10.
- `rst_n` pulsed low mid-TURN between clock edges → outputs go to 00/00 and `state_o`=0 without waiting for a clock edge. Random-stimulus check: no clock ever shows motor encoding 11.
